// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch hazard controller.
package branch_ctrl_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int REG_AW    = 5;

  // Producer stages checked against the ID-stage sources
  localparam int NUM_STG = 2;
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/branch_hazard_ctrl_hazard_match.sv
// Detects that one producer stage writes a register the ID stage is reading.
module hazard_match
  import branch_ctrl_pkg::*;
(
  input  logic              reg_write_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              match_o
);

  // x0 is hardwired to zero, so writes to it never create a dependency
  assign match_o = reg_write_i && (rd_i != '0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Stall/flush control for branches resolved in ID, with saturating
// statistics counters for branches, taken branches and stall cycles.
module branch_hazard_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              ID_Branch_i,
  input  logic [REG_AW-1:0] ID_RS1addr_i,
  input  logic [REG_AW-1:0] ID_RS2addr_i,
  input  logic              ID_branch_ctr_i,
  input  logic              EX_RegWrite_i,
  input  logic              EX_MemRead_i,
  input  logic [REG_AW-1:0] EX_RDaddr_i,
  input  logic              MEM_RegWrite_i,
  input  logic              MEM_MemRead_i,
  input  logic [REG_AW-1:0] MEM_RDaddr_i,
  output logic              PCWrite_o,
  output logic              IFID_Write_o,
  output logic              IDEX_Bubble_o,
  output logic              IFID_Flush_o,
  output logic              PCSrc_o,
  output logic [CNT_W-1:0]  br_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [NUM_STG-1:0]             stg_reg_write;
  logic [NUM_STG-1:0][REG_AW-1:0] stg_rd;
  logic [NUM_STG-1:0]             stg_match;

  assign stg_reg_write = {MEM_RegWrite_i, EX_RegWrite_i};
  assign stg_rd        = {MEM_RDaddr_i, EX_RDaddr_i};

  generate
    for (genvar gi = 0; gi < NUM_STG; gi++) begin : g_stage
      hazard_match u_match (
        .reg_write_i (stg_reg_write[gi]),
        .rd_i        (stg_rd[gi]),
        .rs1_i       (ID_RS1addr_i),
        .rs2_i       (ID_RS2addr_i),
        .match_o     (stg_match[gi])
      );
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic run;
  logic haz_br_ex_load;
  logic haz_br_ex_alu;
  logic haz_br_mem_load;
  logic haz_nb_ex_load;
  logic hazard;
  logic stall;
  logic br_resolve;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Holding rst_i low also forces the free-running control pattern
  assign run = start_i && rst_i;

  assign haz_br_ex_load  = ID_Branch_i  && stg_match[STG_EX]  && EX_MemRead_i;
  assign haz_br_ex_alu   = ID_Branch_i  && stg_match[STG_EX]  && !EX_MemRead_i;
  assign haz_br_mem_load = ID_Branch_i  && stg_match[STG_MEM] && MEM_MemRead_i;
  assign haz_nb_ex_load  = !ID_Branch_i && stg_match[STG_EX]  && EX_MemRead_i;
  assign hazard = haz_br_ex_load || haz_br_ex_alu || haz_br_mem_load || haz_nb_ex_load;

  always_comb begin
    state_d       = IDLE;
    stall         = 1'b0;
    br_resolve    = 1'b0;
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_Bubble_o = 1'b0;
    IFID_Flush_o  = 1'b0;
    PCSrc_o       = 1'b0;

    if (run) begin
      case (state_q)
        IDLE: begin
          stall = hazard;
          // A branch waiting on a load still in EX needs the data two cycles later
          if (haz_br_ex_load) state_d = HOLD;
        end
        HOLD: begin
          stall   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (stall) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IDEX_Bubble_o = 1'b1;
    end else if (run && ID_Branch_i) begin
      br_resolve = 1'b1;
      if (ID_branch_ctr_i) begin
        PCSrc_o      = 1'b1;
        IFID_Flush_o = 1'b1;
      end
    end

    br_cnt_d    = sat_inc(br_cnt_q, br_resolve);
    taken_cnt_d = sat_inc(taken_cnt_q, br_resolve && ID_branch_ctr_i);
    stall_cnt_d = sat_inc(stall_cnt_q, stall);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign br_cnt_o    = br_cnt_q;
  assign taken_cnt_o = taken_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Scenario tasks plus a randomized run against a behavioural model.
module tb_branch_hazard_ctrl;

  localparam logic [4:0] CTL_RUN   = 5'b11000;  // {PCWrite, IFID_Write, Bubble, Flush, PCSrc}
  localparam logic [4:0] CTL_STALL = 5'b00100;
  localparam logic [4:0] CTL_TAKEN = 5'b11011;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  logic id_br = 1'b0, ctr = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0, mem_rd = '0;
  logic ex_rw = 1'b0, ex_mr = 1'b0, mem_rw = 1'b0, mem_mr = 1'b0;

  logic pc_write, ifid_write, bubble, flush, pcsrc;
  logic [15:0] br_cnt, taken_cnt, stall_cnt;
  logic s_pc_write, s_ifid_write, s_bubble, s_flush, s_pcsrc;
  logic [3:0] s_br_cnt, s_taken_cnt, s_stall_cnt;
  logic [4:0] ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {pc_write, ifid_write, bubble, flush, pcsrc};

  always #5 clk_i = ~clk_i;

  branch_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ID_Branch_i(id_br), .ID_RS1addr_i(rs1), .ID_RS2addr_i(rs2), .ID_branch_ctr_i(ctr),
    .EX_RegWrite_i(ex_rw), .EX_MemRead_i(ex_mr), .EX_RDaddr_i(ex_rd),
    .MEM_RegWrite_i(mem_rw), .MEM_MemRead_i(mem_mr), .MEM_RDaddr_i(mem_rd),
    .PCWrite_o(pc_write), .IFID_Write_o(ifid_write), .IDEX_Bubble_o(bubble),
    .IFID_Flush_o(flush), .PCSrc_o(pcsrc),
    .br_cnt_o(br_cnt), .taken_cnt_o(taken_cnt), .stall_cnt_o(stall_cnt)
  );

  branch_hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ID_Branch_i(id_br), .ID_RS1addr_i(rs1), .ID_RS2addr_i(rs2), .ID_branch_ctr_i(ctr),
    .EX_RegWrite_i(ex_rw), .EX_MemRead_i(ex_mr), .EX_RDaddr_i(ex_rd),
    .MEM_RegWrite_i(mem_rw), .MEM_MemRead_i(mem_mr), .MEM_RDaddr_i(mem_rd),
    .PCWrite_o(s_pc_write), .IFID_Write_o(s_ifid_write), .IDEX_Bubble_o(s_bubble),
    .IFID_Flush_o(s_flush), .PCSrc_o(s_pcsrc),
    .br_cnt_o(s_br_cnt), .taken_cnt_o(s_taken_cnt), .stall_cnt_o(s_stall_cnt)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    id_br = 0; ctr = 0; rs1 = 0; rs2 = 0;
    ex_rw = 0; ex_mr = 0; ex_rd = 0;
    mem_rw = 0; mem_mr = 0; mem_rd = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 0;
    #2;
    rst_i = 1;
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #1;
    start_i = 1; id_br = 1; ctr = 1; rs1 = 5; ex_rw = 1; ex_mr = 1; ex_rd = 5;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RUN);
    end
    tick();
    checks++;
    if ({br_cnt, taken_cnt, stall_cnt} !== 48'd0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h/%h want 0/0/0", br_cnt, taken_cnt, stall_cnt);
    end
    clear_inputs();
    rst_i = 1;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_load_branch();
    do_reset();
    start_i = 1; id_br = 1; rs1 = 5; rs2 = 9; ex_rw = 1; ex_mr = 1; ex_rd = 5;
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL load_br_stall1: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    ex_rw = 0; ex_mr = 0; ex_rd = 0;
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL load_br_stall2: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    checks++;
    if (ctl !== CTL_RUN || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL load_br_resolve: got ctl=%b stall=%0d want ctl=%b stall=2", ctl, stall_cnt, CTL_RUN);
    end
    tick();
    checks++;
    if (br_cnt !== 16'd1 || taken_cnt !== 16'd0 || stall_cnt !== 16'd2) begin
      errors++; $display("FAIL load_br_cnt: got %0d/%0d/%0d want 1/0/2", br_cnt, taken_cnt, stall_cnt);
    end
    $display("test_load_branch done");
  endtask

  task automatic test_alu_branch();
    do_reset();
    start_i = 1; id_br = 1; rs1 = 1; rs2 = 7; ex_rw = 1; ex_mr = 0; ex_rd = 7;
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL alu_br_stall: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    ex_rw = 0; ctr = 1;
    #1;
    checks++;
    if (ctl !== CTL_TAKEN || stall_cnt !== 16'd1) begin
      errors++; $display("FAIL alu_br_taken: got ctl=%b stall=%0d want ctl=%b stall=1", ctl, stall_cnt, CTL_TAKEN);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (ctl !== CTL_RUN || br_cnt !== 16'd1 || taken_cnt !== 16'd1) begin
      errors++; $display("FAIL alu_br_after: got ctl=%b br=%0d taken=%0d want ctl=%b br=1 taken=1", ctl, br_cnt, taken_cnt, CTL_RUN);
    end
    $display("test_alu_branch done");
  endtask

  task automatic test_zero_reg();
    do_reset();
    start_i = 1; id_br = 1; rs1 = 0; rs2 = 4; ex_rw = 1; ex_mr = 1; ex_rd = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL zero_reg_ctl: got %b want %b", ctl, CTL_RUN);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd0 || br_cnt !== 16'd1) begin
      errors++; $display("FAIL zero_reg_cnt: got stall=%0d br=%0d want stall=0 br=1", stall_cnt, br_cnt);
    end
    $display("test_zero_reg done");
  endtask

  task automatic test_nonbranch();
    do_reset();
    start_i = 1; id_br = 0; rs1 = 3; rs2 = 8; ex_rw = 1; ex_mr = 1; ex_rd = 3;
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL nb_load_stall: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    ex_mr = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL nb_alu_nostall: got %b want %b", ctl, CTL_RUN);
    end
    tick();
    checks++;
    if (stall_cnt !== 16'd1 || br_cnt !== 16'd0) begin
      errors++; $display("FAIL nb_cnt: got stall=%0d br=%0d want stall=1 br=0", stall_cnt, br_cnt);
    end
    $display("test_nonbranch done");
  endtask

  task automatic test_priority_and_reset();
    do_reset();
    start_i = 1; id_br = 1; ctr = 1; rs1 = 5; ex_rw = 1; ex_mr = 1; ex_rd = 5;
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL prio_no_flush: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    rst_i = 0;
    #1;
    checks++;
    if (ctl !== CTL_RUN || {br_cnt, taken_cnt, stall_cnt} !== 48'd0) begin
      errors++; $display("FAIL hold_reset: got ctl=%b cnt=%0d/%0d/%0d want ctl=%b cnt=0/0/0", ctl, br_cnt, taken_cnt, stall_cnt, CTL_RUN);
    end
    clear_inputs();
    rst_i = 1;
    #1;
    checks++;
    if (ctl !== CTL_RUN) begin
      errors++; $display("FAIL hold_abandoned: got %b want %b", ctl, CTL_RUN);
    end
    $display("test_priority_and_reset done");
  endtask

  task automatic test_saturation();
    do_reset();
    start_i = 1; id_br = 1; ctr = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (s_br_cnt !== 4'd15 || s_taken_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_reach: got %0d/%0d want 15/15", s_br_cnt, s_taken_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (s_br_cnt !== 4'd15 || s_taken_cnt !== 4'd15 || br_cnt !== 16'd20) begin
      errors++; $display("FAIL sat_hold: got small %0d/%0d wide %0d want 15/15 wide 20", s_br_cnt, s_taken_cnt, br_cnt);
    end
    id_br = 0; ctr = 0; rs1 = 2; ex_rw = 1; ex_mr = 1; ex_rd = 2;
    for (int i = 0; i < 18; i++) tick();
    checks++;
    if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd18) begin
      errors++; $display("FAIL sat_stall: got small %0d wide %0d want 15 and 18", s_stall_cnt, stall_cnt);
    end
    $display("test_saturation done");
  endtask

  task automatic test_random();
    bit m_hold;
    int m_br, m_tk, m_st;
    bit ex_hit, mem_hit, haz, e_stall, e_take;
    logic [4:0] e_ctl;
    do_reset();
    m_hold = 0; m_br = 0; m_tk = 0; m_st = 0;
    for (int n = 0; n < 400; n++) begin
      start_i = ($urandom_range(0, 9) != 0);
      id_br = $urandom_range(0, 1); ctr = $urandom_range(0, 1);
      rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
      ex_rw = $urandom_range(0, 1); ex_mr = $urandom_range(0, 1); ex_rd = 5'($urandom_range(0, 3));
      mem_rw = $urandom_range(0, 1); mem_mr = $urandom_range(0, 1); mem_rd = 5'($urandom_range(0, 3));
      #1;
      ex_hit  = ex_rw && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2);
      mem_hit = mem_rw && mem_rd != 0 && (mem_rd == rs1 || mem_rd == rs2);
      haz = id_br ? (ex_hit || (mem_hit && mem_mr)) : (ex_hit && ex_mr);
      e_stall = start_i && (m_hold || haz);
      e_take = start_i && !e_stall && id_br && ctr;
      e_ctl = e_stall ? CTL_STALL : (e_take ? CTL_TAKEN : CTL_RUN);
      checks++;
      if (ctl !== e_ctl) begin
        errors++; $display("FAIL rand_ctl[%0d]: got %b want %b", n, ctl, e_ctl);
      end
      checks++;
      if (br_cnt !== 16'(m_br) || taken_cnt !== 16'(m_tk) || stall_cnt !== 16'(m_st)) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d", n, br_cnt, taken_cnt, stall_cnt, m_br, m_tk, m_st);
      end
      if (start_i && !e_stall && id_br) begin
        m_br = (m_br < 65535) ? m_br + 1 : m_br;
        if (ctr) m_tk = (m_tk < 65535) ? m_tk + 1 : m_tk;
      end
      if (e_stall) m_st = (m_st < 65535) ? m_st + 1 : m_st;
      m_hold = start_i && !m_hold && id_br && ex_hit && ex_mr;
      @(posedge clk_i);
      #1;
    end
    $display("test_random done: br=%0d taken=%0d stall=%0d", m_br, m_tk, m_st);
  endtask

  initial begin
    test_reset();
    test_load_branch();
    test_alu_branch();
    test_zero_reg();
    test_nonbranch();
    test_priority_and_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
